// File: rtl/rv_muldiv_unit_if.sv
// Request/response bundle for the iterative M-extension unit.
// master drives requests and the result handshake, slave is the unit.
interface rv_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_in;
  logic            ready_out;
  logic [XLEN-1:0] op_1_in;
  logic [XLEN-1:0] op_2_in;
  logic [2:0]      funct3_in;
  logic            kill_in;
  logic            valid_out;
  logic            ready_in;
  logic [XLEN-1:0] result_out;

  modport master (
    output valid_in,
    output op_1_in,
    output op_2_in,
    output funct3_in,
    output kill_in,
    output ready_in,
    input  ready_out,
    input  valid_out,
    input  result_out
  );

  modport slave (
    input  valid_in,
    input  op_1_in,
    input  op_2_in,
    input  funct3_in,
    input  kill_in,
    input  ready_in,
    output ready_out,
    output valid_out,
    output result_out
  );
endinterface

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32/64 M-extension unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, sign fix-up in a final cycle.
module rv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  rv_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      fn;
  logic            neg;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] res;

  logic            accept;
  logic            sgn_1;
  logic            sgn_2;
  logic            neg_1;
  logic            neg_2;
  logic            neg_in;
  logic [XLEN-1:0] mag_1;
  logic [XLEN-1:0] mag_2;
  logic            div_zero;
  logic            div_ovf;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic              is_mul_lo;
  logic              is_mul_hi;
  logic              is_quo;
  logic              is_rem;
  logic [XLEN-1:0]   fix_res;

  assign accept = bus.valid_in & (state == IDLE) & ~bus.kill_in;

  always_comb begin
    sgn_1 = 1'b0;
    sgn_2 = 1'b0;
    unique case (bus.funct3_in)
      F_MULH, F_DIV, F_REM: begin
        sgn_1 = 1'b1;
        sgn_2 = 1'b1;
      end
      F_MULHSU: sgn_1 = 1'b1;
      default: ;
    endcase
  end

  assign neg_1 = sgn_1 & bus.op_1_in[XLEN-1];
  assign neg_2 = sgn_2 & bus.op_2_in[XLEN-1];
  // MIN_NEG negates to itself, which is already its unsigned magnitude
  assign mag_1 = neg_1 ? -bus.op_1_in : bus.op_1_in;
  assign mag_2 = neg_2 ? -bus.op_2_in : bus.op_2_in;
  assign neg_in = (bus.funct3_in == F_REM) ? neg_1
                                           : (neg_1 ^ neg_2);

  assign div_zero = bus.funct3_in[2] & (bus.op_2_in == '0);
  assign div_ovf  = bus.funct3_in[2] & ~bus.funct3_in[0] &
                    (bus.op_1_in == MIN_NEG) &
                    (bus.op_2_in == '1);
  assign fast = div_zero | div_ovf;

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = bus.funct3_in[1] ? bus.op_1_in : '1;
    end else begin
      fast_res = bus.funct3_in[1] ? '0 : bus.op_1_in;
    end
  end

  // hi:lo is the product (mul) or remainder:quotient (div)
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
  assign div_sh   = {hi, lo[XLEN-1]};
  assign div_diff = div_sh - {1'b0, b};

  assign prod     = {hi, lo};
  assign prod_fix = neg ? -prod : prod;
  assign quo_fix  = neg ? -lo : lo;
  assign rem_fix  = neg ? -hi : hi;

  assign is_mul_lo = (fn == F_MUL);
  assign is_mul_hi = ~fn[2] & (|fn[1:0]);
  assign is_quo    = fn[2] & ~fn[1];
  assign is_rem    = fn[2] & fn[1];

  always_comb begin
    fix_res = '0;
    unique case (1'b1)
      is_mul_lo: fix_res = prod_fix[XLEN-1:0];
      is_mul_hi: fix_res = prod_fix[2*XLEN-1:XLEN];
      is_quo:    fix_res = quo_fix;
      is_rem:    fix_res = rem_fix;
      default:   fix_res = '0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
      fn    <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      b     <= '0;
      res   <= '0;
    end else if (bus.kill_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            fn  <= bus.funct3_in;
            neg <= neg_in;
            hi  <= '0;
            lo  <= mag_1;
            b   <= mag_2;
            if (fast) begin
              res   <= fast_res;
              state <= DONE;
            end else begin
              cnt   <= CNT_INIT;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (fn[2]) begin
            lo <= {lo[XLEN-2:0], ~div_diff[XLEN]};
            hi <= div_diff[XLEN] ? div_sh[XLEN-1:0]
                                 : div_diff[XLEN-1:0];
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          res   <= fix_res;
          state <= DONE;
        end
        DONE: begin
          if (bus.ready_in) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_out  = (state == IDLE);
  assign bus.valid_out  = (state == DONE);
  assign bus.result_out = (state == DONE) ? res : '0;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Randomised bench for rv_muldiv_unit against a plain-arithmetic model;
// a negedge monitor compares handshake, latency and result every cycle.
module tb_rv_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;

  rv_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  rv_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];

  function automatic logic [31:0] ref_op(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa;
    longint sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p = '0;
    r = '0;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = ALL1;
        else if (a == MIN_NEG && b == ALL1) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? ALL1 : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MIN_NEG && b == ALL1) r = 0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == MIN_NEG && b == ALL1)
      return 1;
    return XLEN + 2;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  logic        m_idle;
  logic        m_ev;
  logic [31:0] m_er;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
      chk("rst_ready_out", 64'(bus.ready_out), 64'd1);
      chk("rst_result_out", 64'(bus.result_out), 64'd0);
      q.delete();
    end else begin
      m_idle = (q.size() == 0);
      m_ev = !m_idle && (cyc - q[0].acc + 1 >= q[0].lat);
      m_er = m_ev ? q[0].res : 32'h0;
      chk("ready_out", 64'(bus.ready_out), 64'(m_idle));
      chk("valid_out", 64'(bus.valid_out), 64'(m_ev));
      chk("result_out", 64'(bus.result_out), 64'(m_er));
      if (bus.kill_in) begin
        q.delete();
      end else begin
        if (m_ev && bus.ready_in) void'(q.pop_front());
        if (m_idle && bus.valid_in)
          q.push_back('{res: ref_op(bus.funct3_in, bus.op_1_in,
                                    bus.op_2_in),
                        lat: ref_lat(bus.funct3_in, bus.op_1_in,
                                     bus.op_2_in),
                        acc: cyc + 1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b);
    int n = 0;
    while (!bus.ready_out && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(bus.ready_out), 64'd1);
    bus.funct3_in = f;
    bus.op_1_in = a;
    bus.op_2_in = b;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.funct3_in = 3'($urandom);
    bus.op_1_in = $urandom;
    bus.op_2_in = $urandom;
  endtask

  task automatic collect(input int hold);
    int n = 0;
    while (!bus.valid_out && n < 100) begin
      tick();
      n++;
    end
    chk("valid_wait", 64'(bus.valid_out), 64'd1);
    repeat (hold) tick();
    bus.ready_in = 1'b1;
    tick();
    bus.ready_in = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return ALL1;
      3: return MIN_NEG;
      4: return 32'($urandom_range(0, 15));
      5: return 32'(-$urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  d_f [12];
  logic [31:0] d_a [12];
  logic [31:0] d_b [12];
  logic [31:0] d_r [12];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    d_f = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6,
            3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    d_a = '{32'h5, ALL1, ALL1, ALL1, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
            32'h7, 32'h7, 32'h5, 32'h5, MIN_NEG, MIN_NEG};
    d_b = '{32'h3, 32'h1, 32'h1, ALL1, 32'h2, 32'h2,
            32'h2, 32'h2, 32'h0, 32'h0, ALL1, ALL1};
    d_r = '{32'hF, ALL1, 32'h0, ALL1, 32'hFFFF_FFFD, ALL1,
            32'h3, 32'h1, ALL1, 32'h5, MIN_NEG, 32'h0};

    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.kill_in = 1'b0;
    bus.ready_in = 1'b0;
    bus.funct3_in = 3'd0;
    bus.op_1_in = '0;
    bus.op_2_in = '0;
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      chk("model_literal", 64'(ref_op(d_f[i], d_a[i], d_b[i])),
          64'(d_r[i]));
    chk("model_lat_mul", 64'(ref_lat(3'd0, 32'h5, 32'h3)), 64'd34);
    chk("model_lat_div0", 64'(ref_lat(3'd4, 32'h5, 32'h0)), 64'd1);
    chk("model_lat_ovf", 64'(ref_lat(3'd6, MIN_NEG, ALL1)), 64'd1);

    for (int i = 0; i < 12; i++) begin
      send(d_f[i], d_a[i], d_b[i]);
      collect(0);
    end

    send(3'd0, 32'h1234, 32'h5678);
    collect(10);

    send(3'd4, 32'd1000, 32'd7);
    repeat (9) tick();
    bus.kill_in = 1'b1;
    tick();
    bus.kill_in = 1'b0;
    chk("kill_calc_ready", 64'(bus.ready_out), 64'd1);
    chk("kill_calc_valid", 64'(bus.valid_out), 64'd0);
    repeat (40) tick();

    send(3'd0, 32'h3, 32'h4);
    repeat (40) tick();
    bus.kill_in = 1'b1;
    tick();
    bus.kill_in = 1'b0;
    chk("kill_done_valid", 64'(bus.valid_out), 64'd0);

    bus.funct3_in = 3'd0;
    bus.op_1_in = 32'h9;
    bus.op_2_in = 32'h9;
    bus.valid_in = 1'b1;
    bus.kill_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.kill_in = 1'b0;
    chk("kill_block_ready", 64'(bus.ready_out), 64'd1);
    repeat (40) tick();

    send(3'd5, $urandom, 32'h3);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(bus.valid_out), 64'd0);
    chk("async_rst_ready", 64'(bus.ready_out), 64'd1);
    chk("async_rst_result", 64'(bus.result_out), 64'd0);
    tick();
    rst = 1'b0;
    send(3'd0, 32'h6, 32'h7);
    collect(1);

    for (int i = 0; i < 150; i++) begin
      send(3'($urandom), pick(), pick());
      collect($urandom_range(0, 3));
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_muldiv_unit.md
RV_MULDIV_UNIT -- requirements
Module: rv_muldiv_unit

Interface
REQ-001 Parameter XLEN SHALL default to 32 and give the operand and result width; legal values are even and 8..64.
REQ-002 clk_in  input  1  single clock, all state on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 valid_in  input  1  request valid.
REQ-005 ready_out  output  1  unit can accept a request.
REQ-006 op_1_in  input  XLEN  rs1 operand (multiplicand or dividend).
REQ-007 op_2_in  input  XLEN  rs2 operand (multiplier or divisor).
REQ-008 funct3_in  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 kill_in  input  1  synchronous abort of any in-flight operation.
REQ-010 valid_out  output  1  result_out holds a valid result.
REQ-011 ready_in  input  1  consumer accepts the result.
REQ-012 result_out  output  XLEN  operation result.

Function
REQ-013 States SHALL be IDLE, CALC, FIX and DONE; ready_out = 1 only in IDLE; valid_out = 1 only in DONE.
REQ-014 A request SHALL be accepted on a rising edge with valid_in & ready_out & !kill_in; operands and funct3 latched then; later input changes have no effect.
REQ-015 Accept SHALL go to CALC with iteration counter = XLEN, except the fast-path cases in REQ-020/021, which go directly to DONE.
REQ-016 CALC SHALL perform one radix-2 step per cycle (shift-add multiply; restoring divide on operand magnitudes), decrement the counter, and go to FIX after XLEN cycles.
REQ-017 FIX SHALL apply sign correction and select the output, then go to DONE; normal latency is XLEN+2 edges from accept to valid_out high (34 for XLEN=32).
REQ-018 Multiply SHALL form the 2*XLEN product; MUL returns the low XLEN bits; MULH (signed x signed), MULHSU (signed op_1 x unsigned op_2) and MULHU (unsigned x unsigned) return the high XLEN bits.
REQ-019 Signed divide SHALL truncate toward zero; the REM sign equals the dividend sign; DIVU/REMU are unsigned.
REQ-020 Divide by zero SHALL complete in 1 edge: DIV/DIVU return all-ones; REM/REMU return op_1.
REQ-021 Signed overflow (op_1 = most-negative, op_2 = all-ones) SHALL complete in 1 edge: DIV returns op_1; REM returns 0.
REQ-022 DONE SHALL hold valid_out and a stable result_out until ready_in = 1; on that edge the unit returns to IDLE (no accept on the same edge).
REQ-023 kill_in = 1 SHALL force IDLE on the next edge from any state, discard the in-flight result, and block accept on that edge.
REQ-024 result_out SHALL be 0 whenever valid_out = 0.

Reset
REQ-025 On rst_in assertion, the unit SHALL go to IDLE immediately, asynchronously, from any state: valid_out = 0, result_out = 0, ready_out = 1, counter and datapath registers = 0.
REQ-026 Reset asserted during CALC or DONE SHALL discard the operation; no valid_out after release.
REQ-027 After rst_in deasserts, the first accept SHALL be possible on the first rising edge.

Verification (XLEN=32)
REQ-028 MUL 0x00000005 x 0x00000003 -> result 0x0000000F, valid_out exactly 34 edges after accept.
REQ-029 op_1 = 0xFFFFFFFF: with op_2 = 0x00000001, MULH -> 0xFFFFFFFF and MULHU -> 0x00000000; with op_2 = 0xFFFFFFFF, MULHSU -> 0xFFFFFFFF.
REQ-030 op_1 = 0xFFFFFFF9, op_2 = 2: DIV -> 0xFFFFFFFD, REM -> 0xFFFFFFFF. op_1 = 7, op_2 = 2: DIVU -> 0x00000003, REMU -> 0x00000001.
REQ-031 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. Each with valid_out one edge after accept.
REQ-032 ready_in held low 10 cycles in DONE -> valid_out and result_out stable and ready_out = 0 throughout; return to IDLE on the ready_in edge.
REQ-033 kill_in pulsed on CALC cycle 10 -> IDLE with ready_out = 1 next edge and no valid_out; rst_in pulsed mid-CALC without a clock edge -> outputs immediately at reset values.
